// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: word-organised RAM with inserted
// wait states, byte-lane store merging, shifted load data and error flags.
//
// state | meaning
// IDLE  | waiting for a load/store request
// BUSY  | counting down inserted wait states
// RESP  | one-cycle response, o_ready high, data and flags valid
module data_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_write,
  input  logic        i_load,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err_misalign,
  output logic        o_err_range
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [30:0] DEPTH_W   = 31'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] mem [DEPTH];

  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_store;
  logic [3:0]  wait_cnt;
  logic [31:0] rdata;
  logic        err_misalign, err_range;

  logic        request;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_store;
  logic [32:0] offset;
  logic [29:0] idx;
  logic [1:0]  lane;
  logic        in_range, misaligned, commit, do_write;
  logic [31:0] old_word, new_word, load_word;

  assign request = i_write | i_load;

  // With zero wait states the commit edge is the same edge that sees the
  // request, so the transaction fields come straight from the inputs in IDLE.
  assign cur_addr  = (state == IDLE) ? i_addr    : req_addr;
  assign cur_wdata = (state == IDLE) ? i_wdata   : req_wdata;
  assign cur_size  = (state == IDLE) ? i_memsize : req_size;
  assign cur_store = (state == IDLE) ? i_write   : req_store;

  // Bit 32 is the borrow, flagging addresses below BASE_ADDR.
  assign offset   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign idx      = offset[31:2];
  assign lane     = offset[1:0];
  assign in_range = !offset[32] && ({1'b0, idx} < DEPTH_W);

  assign misaligned = cur_store &&
                      (((cur_size == 2'b10) && lane[0]) ||
                       ((cur_size == 2'b11) && (lane != 2'b00)));

  assign commit   = (state_next == RESP);
  assign do_write = commit && cur_store && in_range && !misaligned &&
                    (cur_size != 2'b00);

  assign old_word  = mem[idx[AW-1:0]];
  assign load_word = old_word >> {lane, 3'b000};

  always_comb begin
    new_word = old_word;
    case (cur_size)
      2'b01:   new_word[{lane, 3'b000} +: 8]     = cur_wdata[7:0];
      2'b10:   new_word[{lane[1], 4'b0000} +: 16] = cur_wdata[15:0];
      2'b11:   new_word = cur_wdata;
      default: new_word = old_word;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (request) state_next = (WAIT_INIT == 4'd0) ? RESP : BUSY;
      BUSY:    if (wait_cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      rdata        <= 32'd0;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      req_size     <= 2'b00;
      req_store    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && request) begin
        req_addr  <= i_addr;
        req_wdata <= i_wdata;
        req_size  <= i_memsize;
        req_store <= i_write;
        wait_cnt  <= WAIT_INIT;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        err_range    <= !in_range;
        err_misalign <= in_range && misaligned;
        if (!cur_store) rdata <= in_range ? load_word : 32'd0;
      end else if (state == RESP) begin
        err_range    <= 1'b0;
        err_misalign <= 1'b0;
      end
    end
  end

  // Storage has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && do_write) mem[idx[AW-1:0]] <= new_word;
  end

  assign o_rdata        = rdata;
  assign o_ready        = (state == RESP);
  assign o_busy         = (state != IDLE);
  assign o_err_misalign = err_misalign;
  assign o_err_range    = err_range;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (no wait states at
// base 0, three wait states at a non-zero base) against a word-array model.
module tb_data_mem_responder;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int DEPTH0 = 1024;
  localparam int DEPTH1 = 64;
  localparam int WAIT0  = 0;
  localparam int WAIT1  = 3;

  typedef struct {
    int          d;
    int          id;
    logic [31:0] rdata;
    logic        mis;
    logic        rng;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        wr    [2];
  logic        ld    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  size  [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        busy  [2];
  logic        mis   [2];
  logic        rng   [2];

  exp_t        exp_q[$];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] ref_rdata [2];
  int          errors = 0;
  int          checks = 0;
  int          txn_id = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH0), .BASE_ADDR(BASE0), .WAIT_CYCLES(WAIT0)) u0 (
    .i_clk(clk), .i_rst(rst[0]), .i_write(wr[0]), .i_load(ld[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .i_memsize(size[0]),
    .o_rdata(rdata[0]), .o_ready(ready[0]), .o_busy(busy[0]),
    .o_err_misalign(mis[0]), .o_err_range(rng[0]));

  data_mem_responder #(.DEPTH(DEPTH1), .BASE_ADDR(BASE1), .WAIT_CYCLES(WAIT1)) u1 (
    .i_clk(clk), .i_rst(rst[1]), .i_write(wr[1]), .i_load(ld[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .i_memsize(size[1]),
    .o_rdata(rdata[1]), .o_ready(ready[1]), .o_busy(busy[1]),
    .o_err_misalign(mis[1]), .o_err_range(rng[1]));

  function automatic longint unsigned base_of(int d);
    return (d == 0) ? longint'(BASE0) : longint'(BASE1);
  endfunction

  function automatic int depth_of(int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int wait_of(int d);
    return (d == 0) ? WAIT0 : WAIT1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: memory as plain words, stores as mask-and-merge, loads as a shift.
  function automatic exp_t model_txn(int d, bit is_store, logic [31:0] a,
                                     logic [31:0] wd, logic [1:0] sz);
    exp_t e;
    longint unsigned av, bv, widx;
    int sh;
    bit inr;
    logic [31:0] mask, data, word;
    av = longint'(a);
    bv = base_of(d);
    e.d = d;
    e.id = txn_id++;
    e.mis = 1'b0;
    e.rng = 1'b0;
    inr = (av >= bv) && ((av - bv) / 4 < longint'(depth_of(d)));
    sh = 8 * int'(a % 4);
    if (!inr) begin
      e.rng = 1'b1;
      if (!is_store) ref_rdata[d] = 32'd0;
    end else begin
      widx = (av - bv) / 4;
      word = ref_mem[d][widx];
      if (is_store) begin
        if ((sz == 2'd2 && a % 2 != 0) || (sz == 2'd3 && a % 4 != 0)) begin
          e.mis = 1'b1;
        end else if (sz != 2'd0) begin
          case (sz)
            2'd1:    mask = 32'h0000_00FF;
            2'd2:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
          endcase
          mask = mask << sh;
          data = wd << sh;
          ref_mem[d][widx] = (word & ~mask) | (data & mask);
        end
      end else begin
        ref_rdata[d] = word >> sh;
      end
    end
    e.rdata = ref_rdata[d];
    return e;
  endfunction

  // Monitor: every o_ready pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d] && ready[d]) begin
        if (exp_q.size() == 0 || exp_q[0].d != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d: got o_ready=1, expected none", d);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("dut%0d txn%0d rdata", d, e.id), rdata[d], e.rdata);
          check($sformatf("dut%0d txn%0d misalign", d, e.id), 32'(mis[d]), 32'(e.mis));
          check($sformatf("dut%0d txn%0d range", d, e.id), 32'(rng[d]), 32'(e.rng));
        end
      end
    end
  end

  task automatic wait_idle(int d);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy[d]) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout dut%0d: got o_busy=1, expected 0", d);
    end
  endtask

  task automatic check_reset_state(int d);
    check($sformatf("dut%0d reset rdata", d), rdata[d], 32'd0);
    check($sformatf("dut%0d reset ready", d), 32'(ready[d]), 32'd0);
    check($sformatf("dut%0d reset busy", d), 32'(busy[d]), 32'd0);
    check($sformatf("dut%0d reset misalign", d), 32'(mis[d]), 32'd0);
    check($sformatf("dut%0d reset range", d), 32'(rng[d]), 32'd0);
  endtask

  task automatic do_req(int d, bit w, bit l, logic [31:0] a, logic [31:0] wd,
                        logic [1:0] sz);
    int cyc, busy_cyc;
    bit done;
    wait_idle(d);
    check($sformatf("dut%0d idle flags", d), {29'd0, ready[d], mis[d], rng[d]}, 32'd0);
    wr[d] = w; ld[d] = l; addr[d] = a; wdata[d] = wd; size[d] = sz;
    exp_q.push_back(model_txn(d, w, a, wd, sz));
    cyc = 0;
    busy_cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy[d]) busy_cyc++;
      if (ready[d]) done = 1'b1;
    end
    wr[d] = 1'b0;
    ld[d] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got no o_ready in %0d cycles, expected %0d", d, cyc, 1 + wait_of(d));
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      check($sformatf("dut%0d latency", d), 32'(cyc), 32'(1 + wait_of(d)));
      check($sformatf("dut%0d busy cycles", d), 32'(busy_cyc), 32'(1 + wait_of(d)));
    end
  endtask

  // Request held across two responses: the IDLE after RESP starts a second one.
  task automatic do_held(int d, bit w, bit l, logic [31:0] a, logic [31:0] wd,
                         logic [1:0] sz);
    int cyc, first, second;
    wait_idle(d);
    wr[d] = w; ld[d] = l; addr[d] = a; wdata[d] = wd; size[d] = sz;
    exp_q.push_back(model_txn(d, w, a, wd, sz));
    exp_q.push_back(model_txn(d, w, a, wd, sz));
    cyc = 0;
    first = -1;
    second = -1;
    while (second < 0 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready[d]) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    wr[d] = 1'b0;
    ld[d] = 1'b0;
    check($sformatf("dut%0d held first latency", d), 32'(first), 32'(1 + wait_of(d)));
    check($sformatf("dut%0d held spacing", d), 32'(second - first), 32'(2 + wait_of(d)));
    while (exp_q.size() > 0 && second < 0) void'(exp_q.pop_back());
  endtask

  // Reset in cycle N+rst_at of a transaction issued in cycle N: nothing commits.
  task automatic do_abort(int d, bit w, bit l, logic [31:0] a, logic [31:0] wd,
                          logic [1:0] sz, int rst_at);
    wait_idle(d);
    wr[d] = w; ld[d] = l; addr[d] = a; wdata[d] = wd; size[d] = sz;
    for (int k = 0; k < rst_at; k++) @(negedge clk);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    wr[d] = 1'b0;
    ld[d] = 1'b0;
    ref_rdata[d] = 32'd0;
    check_reset_state(d);
  endtask

  task automatic rand_txn(int d);
    logic [31:0] a, b, top;
    int kind, r;
    b = 32'(base_of(d));
    top = b + 32'(4 * depth_of(d));
    r = int'($urandom_range(0, 9));
    if (r == 0) a = top + $urandom_range(0, 63);
    else if (r == 1) a = (d == 1) ? b - 32'd1 - $urandom_range(0, 15) : top - 32'd4 + $urandom_range(0, 3);
    else a = b + $urandom_range(0, 4 * depth_of(d) - 1);
    kind = int'($urandom_range(0, 2));
    do_req(d, kind != 1, kind != 0, a, $urandom, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; wr[d] = 1'b0; ld[d] = 1'b0;
      addr[d] = 32'd0; wdata[d] = 32'd0; size[d] = 2'd0;
      ref_rdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_reset_state(0);
    check_reset_state(1);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < depth_of(d); i++)
        do_req(d, 1'b1, 1'b0, 32'(base_of(d)) + 32'(4 * i), $urandom, 2'd3);

    do_req(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 2'd3);
    do_req(0, 0, 1, 32'h10, 32'h0, 2'd0);
    do_req(0, 1, 0, 32'h12, 32'h0000_0055, 2'd1);
    do_req(0, 0, 1, 32'h10, 32'h0, 2'd0);
    do_req(0, 0, 1, 32'h13, 32'h0, 2'd0);
    do_req(0, 1, 0, 32'h14, 32'h0, 2'd3);
    do_req(0, 1, 0, 32'h16, 32'hABCD_1234, 2'd2);
    do_req(0, 0, 1, 32'h16, 32'h0, 2'd0);
    do_req(0, 1, 0, 32'h11, 32'h0000_7777, 2'd2);
    do_req(0, 1, 0, 32'h12, 32'h0000_7777, 2'd3);
    do_req(0, 0, 1, 32'h10, 32'h0, 2'd0);
    do_req(0, 0, 1, 32'h1000, 32'h0, 2'd0);
    do_req(0, 1, 0, 32'h1000, 32'h1111_1111, 2'd3);
    do_req(0, 0, 1, 32'h0FFC, 32'h0, 2'd0);
    do_req(0, 1, 1, 32'h20, 32'hCAFE_F00D, 2'd3);
    do_req(0, 1, 0, 32'h24, 32'h5555_5555, 2'd0);
    do_req(0, 0, 1, 32'h21, 32'h0, 2'd0);
    do_abort(0, 1, 0, 32'h20, 32'h0BAD_0BAD, 2'd3, 0);
    do_req(0, 0, 1, 32'h20, 32'h0, 2'd0);

    do_req(1, 0, 1, BASE1, 32'h0, 2'd0);
    do_req(1, 0, 1, BASE1 - 32'd4, 32'h0, 2'd0);
    do_req(1, 0, 1, BASE1 + 32'd256, 32'h0, 2'd0);
    do_req(1, 0, 1, BASE1 + 32'd252, 32'h0, 2'd0);
    do_held(1, 0, 1, BASE1 + 32'd8, 32'h0, 2'd0);
    do_abort(1, 1, 0, BASE1 + 32'd8, 32'h1234_5678, 2'd3, 2);
    do_req(1, 0, 1, BASE1 + 32'd8, 32'h0, 2'd0);
    do_abort(1, 1, 0, BASE1 + 32'd8, 32'h8765_4321, 2'd3, 3);
    do_req(1, 0, 1, BASE1 + 32'd8, 32'h0, 2'd0);
    do_abort(1, 0, 1, BASE1 + 32'd12, 32'h0, 2'd0, 2);

    for (int i = 0; i < 150; i++) begin
      rand_txn(0);
      rand_txn(1);
    end

    repeat (10) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data port: services the CPU's load/store requests (write, load, addr, store data, memsize) against an internal word-organised RAM.
- Adds configurable wait states, byte-lane store merging, load-data alignment, and error flags.
- Sits between the CPU data interface and on-chip storage; the CPU stalls on o_ready.

Parameters:
- DEPTH, 1024, number of 32-bit words of storage (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- WAIT_CYCLES, 0, extra BUSY cycles inserted before each response (0..15).

Ports:
- i_clk  in  1  system clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_write  in  1  store request
- i_load  in  1  load request
- i_addr  in  32  byte address
- i_wdata  in  32  store data; the byte or half is taken from the low bits
- i_memsize  in  2  store size: 01 byte, 10 half, 11 word, 00 no store
- o_rdata  out  32  load result, registered
- o_ready  out  1  one-cycle pulse: transaction complete, o_rdata/flags valid
- o_busy  out  1  high whenever state is not IDLE
- o_err_misalign  out  1  store address not aligned to its size (valid with o_ready)
- o_err_range  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) (valid with o_ready)

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_rdata=0, o_ready=0, o_busy=0, both error flags 0, wait counter 0. RAM contents are not reset.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If i_write|i_load, latch addr, wdata, memsize and type.
  - Both asserted: treated as a store; the load is ignored.
  - Go to BUSY with counter=WAIT_CYCLES; if WAIT_CYCLES=0, go directly to RESP.
- BUSY: decrement the counter; at 1, go to RESP on the next edge.
- Commit: on the edge entering RESP, a store writes the RAM and a load captures o_rdata.
- RESP:
  - o_ready=1 for exactly one cycle, then IDLE unconditionally.
  - Request inputs in RESP are ignored.
- Latency and throughput:
  - Request seen in IDLE at cycle N gives o_ready at cycle N+1+WAIT_CYCLES.
  - Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
  - The requester holds the request until o_ready; a request still high in the IDLE after RESP starts a new transaction.
- Word index: (addr-BASE_ADDR)>>2, 32-bit unsigned subtraction; out of range if addr<BASE_ADDR or index>=DEPTH.
- Store lanes (lane = addr[1:0]):
  - 01: wdata[7:0] written to byte lane addr[1:0].
  - 10: wdata[15:0] written to lanes {addr[1],0},{addr[1],1}.
  - 11: full word.
  - 00: no write, no error. Unselected bytes are unchanged.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, sets o_err_misalign and the RAM is not written.
- Loads:
  - Size is unknown to the responder (the CPU extends locally), so o_rdata = stored_word >> (8*addr[1:0]), logical, zero-filled.
  - Loads never flag misalignment.
- Out of range: stores dropped; loads return o_rdata=0; o_err_range=1. Range takes precedence over misalign: misalign=0 when range=1.
- Error flags are registered at commit and cleared on the cycle after RESP.
- o_rdata holds its value until the next load commit; stores do not change it.
- Reset mid-transaction: abandons the transaction, no RAM write, no o_ready. If reset coincides with the commit edge, reset wins and nothing is written.

Test Plan:
- Reset, then store word 32'hDEADBEEF @0x10 and load @0x10 → o_ready at N+1 (WAIT_CYCLES=0) and o_rdata=32'hDEADBEEF, with no errors.
- With 0x10=32'hDEADBEEF: byte store 8'h55 @0x12, then load @0x10 → 32'hDE55BEEF; load @0x13 → 32'h000000DE.
- Half store 16'h1234 @0x16 over 0, then load @0x16 → 32'h00001234. Half store @0x11 → o_err_misalign=1 and 0x10 unchanged.
- Load @BASE_ADDR+4*DEPTH → o_rdata=0, o_err_range=1, misalign=0. Store there → no RAM change.
- WAIT_CYCLES=3, load request held → o_busy high 4 cycles, o_ready at N+4 for 1 cycle. i_rst asserted at N+2 → no o_ready, state IDLE. A store interrupted this way → memory unchanged.
- i_write and i_load both high with memsize=11 → word stored; o_rdata keeps its prior value.
